control_sequencer: RTL and testbench

//  Moore FSM that drives the register-transfer control inputs of the 32-bit bus datapath.
//  It fetches each instruction through MAR/MDR/IR, decodes it, and runs the ALU execute

---
 rtl/control_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Moore control sequencer for the 32-bit bus datapath: fetch via MAR/MDR/IR,
// decode, then run the three-step ALU execute for register-register operations.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] IR,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [12:0] alu_op,
    output logic        done,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

    state_t      state, next_state;
    logic [2:0]  wait_cnt, wait_cnt_next;
    logic        illegal_next;

    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        op_alu, op_halt, op_hilo, op_unary, final_read;
    logic [12:0] alu_sel;
    logic        unused_ir_bits;

    assign op = IR[31:27];
    assign ra = IR[26:23];
    assign rb = IR[22:19];
    assign rc = IR[18:15];
    assign unused_ir_bits = ^IR[14:0];

    assign op_alu   = (op <= 5'h0C);
    assign op_halt  = (op == 5'h1F);
    assign op_hilo  = (op == 5'h09) || (op == 5'h0A);
    assign op_unary = (op == 5'h0B) || (op == 5'h0C);

    assign final_read = (wait_cnt == 3'(MEM_WAIT));

    // alu_op is ordered {DIV,MUL,NOT,NEG,ROL..ADD}, so ops 09..0C do not map to bit[op]
    always_comb begin
        alu_sel = '0;
        case (op)
            5'h00: alu_sel[0]  = 1'b1;
            5'h01: alu_sel[1]  = 1'b1;
            5'h02: alu_sel[2]  = 1'b1;
            5'h03: alu_sel[3]  = 1'b1;
            5'h04: alu_sel[4]  = 1'b1;
            5'h05: alu_sel[5]  = 1'b1;
            5'h06: alu_sel[6]  = 1'b1;
            5'h07: alu_sel[7]  = 1'b1;
            5'h08: alu_sel[8]  = 1'b1;
            5'h09: alu_sel[11] = 1'b1;
            5'h0A: alu_sel[12] = 1'b1;
            5'h0B: alu_sel[9]  = 1'b1;
            5'h0C: alu_sel[10] = 1'b1;
            default: alu_sel = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
            illegal  <= illegal_next;
        end
    end

    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        illegal_next  = illegal;
        case (state)
            IDLE: if (start) next_state = T0;
            T0:   next_state = T1;
            T1: begin
                if (final_read) begin
                    next_state    = T2;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 3'd1;
                end
            end
            T2:   next_state = T3;
            T3: begin
                if (op_halt) begin
                    next_state = HALT;
                end else if (!op_alu) begin
                    next_state   = HALT;
                    illegal_next = 1'b1;
                end else begin
                    next_state = T4;
                end
            end
            T4:   next_state = T5;
            T5:   next_state = start ? T0 : IDLE;
            HALT: next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Rin     = '0;
        Rout    = '0;
        PCout   = 1'b0;
        IncPC   = 1'b0;
        PCin    = 1'b0;
        MARin   = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        HIin    = 1'b0;
        LOin    = 1'b0;
        alu_op  = '0;
        done    = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC advances only on the last wait cycle so it increments exactly once
                if (final_read) begin
                    PCout = 1'b1;
                    IncPC = 1'b1;
                    PCin  = 1'b1;
                end
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (op_alu) begin
                    Rout = 16'b1 << rb;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                Rout   = 16'b1 << (op_unary ? rb : rc);
                Zin    = 1'b1;
                alu_op = alu_sel;
            end
            T5: begin
                done = 1'b1;
                if (op_hilo) begin
                    HIin = 1'b1;
                    LOin = 1'b1;
                end else begin
                    Zlowout = 1'b1;
                    Rin     = 16'b1 << ra;
                end
            end
            default: ;
        endcase
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each cycle's expected output snapshot
// is queued with the stimulus to apply after it, then popped and compared.
module tb_control_sequencer;

    logic        clock, clear, start, clear_w, start_w;
    logic [31:0] IR, IR_w;
    logic [15:0] Rin, Rout, Rin_w, Rout_w;
    logic PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, HIin, LOin;
    logic PCout_w, IncPC_w, PCin_w, MARin_w, Read_w, MDRin_w, MDRout_w, IRin_w, Yin_w, Zin_w,
          Zlowout_w, HIin_w, LOin_w;
    logic [12:0] alu_op, alu_op_w;
    logic done, halted, illegal, done_w, halted_w, illegal_w;

    control_sequencer #(.MEM_WAIT(0)) dut (
        .clock(clock), .clear(clear), .start(start), .IR(IR), .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .HIin(HIin),
        .LOin(LOin), .alu_op(alu_op), .done(done), .halted(halted), .illegal(illegal)
    );

    control_sequencer #(.MEM_WAIT(2)) dut_w (
        .clock(clock), .clear(clear_w), .start(start_w), .IR(IR_w), .Rin(Rin_w), .Rout(Rout_w),
        .PCout(PCout_w), .IncPC(IncPC_w), .PCin(PCin_w), .MARin(MARin_w), .Read(Read_w),
        .MDRin(MDRin_w), .MDRout(MDRout_w), .IRin(IRin_w), .Yin(Yin_w), .Zin(Zin_w),
        .Zlowout(Zlowout_w), .HIin(HIin_w), .LOin(LOin_w), .alu_op(alu_op_w), .done(done_w),
        .halted(halted_w), .illegal(illegal_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [12:0] S_PCOUT = 13'h1000, S_INCPC = 13'h0800, S_PCIN = 13'h0400,
        S_MARIN = 13'h0200, S_READ = 13'h0100, S_MDRIN = 13'h0080, S_MDROUT = 13'h0040,
        S_IRIN = 13'h0020, S_YIN = 13'h0010, S_ZIN = 13'h0008, S_ZLOWOUT = 13'h0004,
        S_HIIN = 13'h0002, S_LOIN = 13'h0001;

    typedef struct {
        logic [60:0] v;
        logic [31:0] ir;
        logic        st;
        logic        clr;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [60:0] snap0();
        return {Rin, Rout, PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                Zlowout, HIin, LOin, alu_op, done, halted, illegal};
    endfunction

    function automatic logic [60:0] snapw();
        return {Rin_w, Rout_w, PCout_w, IncPC_w, PCin_w, MARin_w, Read_w, MDRin_w, MDRout_w,
                IRin_w, Yin_w, Zin_w, Zlowout_w, HIin_w, LOin_w, alu_op_w, done_w, halted_w,
                illegal_w};
    endfunction

    function automatic logic [60:0] mk(logic [15:0] rin, logic [15:0] rout, logic [12:0] s,
                                       logic [12:0] alu, logic d, logic h, logic i);
        return {rin, rout, s, alu, d, h, i};
    endfunction

    function automatic logic [31:0] enc(logic [4:0] op, logic [3:0] ra, logic [3:0] rb,
                                        logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    // Named ALU line for each opcode: {DIV,MUL,NOT,NEG,ROL,ROR,SHL,SHRA,SHR,OR,AND,SUB,ADD}
    function automatic logic [12:0] alu_bit(logic [4:0] op);
        case (op)
            5'h00: return 13'h0001;  5'h01: return 13'h0002;  5'h02: return 13'h0004;
            5'h03: return 13'h0008;  5'h04: return 13'h0010;  5'h05: return 13'h0020;
            5'h06: return 13'h0040;  5'h07: return 13'h0080;  5'h08: return 13'h0100;
            5'h09: return 13'h0800;  5'h0A: return 13'h1000;  5'h0B: return 13'h0200;
            5'h0C: return 13'h0400;
            default: return 13'h0000;
        endcase
    endfunction

    task automatic push(logic [60:0] v, logic [31:0] ir, logic st, logic clr);
        sb_t e;
        e.v = v; e.ir = ir; e.st = st; e.clr = clr;
        sb.push_back(e);
    endtask

    task automatic push_fetch(logic [31:0] ir, int unsigned mw, logic st);
        push(mk('0, '0, S_PCOUT | S_MARIN, '0, 0, 0, 0), ir, st, 0);
        for (int unsigned i = 0; i < mw; i++)
            push(mk('0, '0, S_READ | S_MDRIN, '0, 0, 0, 0), ir, st, 0);
        push(mk('0, '0, S_READ | S_MDRIN | S_PCOUT | S_INCPC | S_PCIN, '0, 0, 0, 0), ir, st, 0);
        push(mk('0, '0, S_MDROUT | S_IRIN, '0, 0, 0, 0), ir, st, 0);
    endtask

    task automatic push_instr(logic [31:0] ir, int unsigned mw, logic st);
        logic [4:0]  op;
        logic [15:0] one, opnd;
        op  = ir[31:27];
        one = 16'h0001;
        push_fetch(ir, mw, st);
        push(mk('0, one << ir[22:19], S_YIN, '0, 0, 0, 0), ir, st, 0);
        opnd = (op == 5'h0B || op == 5'h0C) ? (one << ir[22:19]) : (one << ir[18:15]);
        push(mk('0, opnd, S_ZIN, alu_bit(op), 0, 0, 0), ir, st, 0);
        if (op == 5'h09 || op == 5'h0A)
            push(mk('0, '0, S_HIIN | S_LOIN, '0, 1, 0, 0), ir, st, 0);
        else
            push(mk(one << ir[26:23], '0, S_ZLOWOUT, '0, 1, 0, 0), ir, st, 0);
    endtask

    task automatic test_reset();
        sb_t e;
        clear = 1; start = 1;
        push('0, IR, 0, 0);
        push('0, IR, 0, 0);
        push('0, IR, 1, 0);
        push(mk('0, '0, S_PCOUT | S_MARIN, '0, 0, 0, 0), IR, 0, 1);
        push('0, IR, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snap0() !== e.v) begin
                errors++;
                $display("FAIL reset left=%0d got %h want %h", sb.size(), snap0(), e.v);
            end
            start = e.st; clear = e.clr; IR = e.ir;
        end
    endtask

    task automatic test_add();
        sb_t e;
        logic [31:0] ir;
        ir = enc(5'h00, 4'd5, 4'd2, 4'd4);
        start = 1;
        push_instr(ir, 0, 0);
        push('0, ir, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snap0() !== e.v) begin
                errors++;
                $display("FAIL add left=%0d got %h want %h", sb.size(), snap0(), e.v);
            end
            start = e.st; clear = e.clr; IR = e.ir;
        end
    endtask

    task automatic test_mul_neg();
        sb_t e;
        start = 1;
        push_instr(enc(5'h09, 4'd6, 4'd3, 4'd1), 0, 1);
        push_instr(enc(5'h0B, 4'd7, 4'd2, 4'd5), 0, 0);
        push('0, IR, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snap0() !== e.v) begin
                errors++;
                $display("FAIL mul_neg left=%0d got %h want %h", sb.size(), snap0(), e.v);
            end
            start = e.st; clear = e.clr; IR = e.ir;
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        start = 1;
        push_instr(enc(5'h01, 4'd0, 4'd0, 4'd15), 0, 1);
        push_instr(enc(5'h0A, 4'd9, 4'd12, 4'd13), 0, 1);
        push_instr(enc(5'h0C, 4'd15, 4'd15, 4'd1), 0, 1);
        push_instr(enc(5'h05, 4'd3, 4'd3, 4'd3), 0, 1);
        push_instr(enc(5'h08, 4'd11, 4'd10, 4'd9), 0, 0);
        push('0, IR, 0, 0);
        push('0, IR, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snap0() !== e.v) begin
                errors++;
                $display("FAIL back_to_back left=%0d got %h want %h", sb.size(), snap0(), e.v);
            end
            start = e.st; clear = e.clr; IR = e.ir;
        end
    endtask

    task automatic test_mem_wait();
        sb_t e;
        logic [31:0] ir;
        ir = enc(5'h00, 4'd5, 4'd2, 4'd4);
        start_w = 1;
        push_instr(ir, 2, 0);
        push('0, ir, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snapw() !== e.v) begin
                errors++;
                $display("FAIL mem_wait left=%0d got %h want %h", sb.size(), snapw(), e.v);
            end
            start_w = e.st; clear_w = e.clr; IR_w = e.ir;
        end
    endtask

    task automatic test_halt();
        sb_t e;
        logic [31:0] ir;
        ir = enc(5'h1F, 4'd1, 4'd2, 4'd3);
        start = 1;
        push_fetch(ir, 0, 1);
        push('0, ir, 1, 0);
        push(mk('0, '0, '0, '0, 0, 1, 0), ir, 1, 0);
        push(mk('0, '0, '0, '0, 0, 1, 0), ir, 1, 0);
        push(mk('0, '0, '0, '0, 0, 1, 0), ir, 0, 1);
        push('0, ir, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snap0() !== e.v) begin
                errors++;
                $display("FAIL halt left=%0d got %h want %h", sb.size(), snap0(), e.v);
            end
            start = e.st; clear = e.clr; IR = e.ir;
        end
    endtask

    task automatic test_illegal();
        sb_t e;
        logic [31:0] ir;
        ir = enc(5'h15, 4'd4, 4'd5, 4'd6);
        start = 1;
        push_fetch(ir, 0, 1);
        push('0, ir, 1, 0);
        for (int i = 0; i < 4; i++)
            push(mk('0, '0, '0, '0, 0, 1, 1), ir, 1, (i == 3));
        push('0, ir, 0, 0);
        push('0, ir, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snap0() !== e.v) begin
                errors++;
                $display("FAIL illegal left=%0d got %h want %h", sb.size(), snap0(), e.v);
            end
            start = e.st; clear = e.clr; IR = e.ir;
        end
    endtask

    task automatic test_clear_mid();
        sb_t e;
        logic [31:0] ir;
        ir = enc(5'h00, 4'd8, 4'd1, 4'd2);
        start = 1;
        push_instr(ir, 0, 0);
        e = sb.pop_back();
        e = sb.pop_back();
        e.clr = 1;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) push('0, ir, 0, 0);
        while (sb.size() != 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++;
            if (snap0() !== e.v) begin
                errors++;
                $display("FAIL clear_mid left=%0d got %h want %h", sb.size(), snap0(), e.v);
            end
            start = e.st; clear = e.clr; IR = e.ir;
        end
    endtask

    initial begin
        clear = 1; start = 0; IR = '0;
        clear_w = 1; start_w = 0; IR_w = '0;
        @(posedge clock); #1;
        clear = 0; clear_w = 0;
        test_reset();
        test_add();
        test_mul_neg();
        test_back_to_back();
        test_mem_wait();
        test_halt();
        test_illegal();
        test_clear_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
